// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the rPLL lock sequencer and its surroundings.
// master = sequencer side, slave = board/PLL side.
interface pll_lock_sequencer_if;
  logic       enable;
  logic       pll_lock;
  logic       pll_reset;
  logic       clk_en;
  logic       pix_rst_n;
  logic       fault;
  logic [2:0] state;
  logic [7:0] relock_count;

  modport master (
    input  enable,
    input  pll_lock,
    output pll_reset,
    output clk_en,
    output pix_rst_n,
    output fault,
    output state,
    output relock_count
  );

  modport slave (
    output enable,
    output pll_lock,
    input  pll_reset,
    input  clk_en,
    input  pix_rst_n,
    input  fault,
    input  state,
    input  relock_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer: filters LOCK, gates the pixel clock,
// releases pixel reset, retries on timeout and latches a fault.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int RST_RELEASE   = 8,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 20
) (
  input logic                  in_clk,
  input logic                  in_rst_n,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SET_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL =
    CNT_W'(RST_RELEASE);
  localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);

  logic [1:0]       sync_q;
  logic             lock_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retries_q, retries_d;
  logic [7:0]       relock_q, relock_d;
  logic             pll_reset_q;
  logic             clk_en_q;
  logic             pix_rst_n_q;
  logic             fault_q;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    relock_d  = relock_q;
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      if (state_q == S_FAULT) retries_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            retries_d = retries_q + 8'd1;
            state_d   = (retries_d == MAX_R) ? S_FAULT
                                             : S_PLL_RST;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SETTLE: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == SET_LAST) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            retries_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
            if (relock_q != 8'hff) relock_d = relock_q + 8'd1;
          end else if (cnt_q < REL) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      sync_q      <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retries_q   <= '0;
      relock_q    <= '0;
      pll_reset_q <= 1'b1;
      clk_en_q    <= 1'b0;
      pix_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.pll_lock};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      relock_q    <= relock_d;
      pll_reset_q <= state_d inside {S_IDLE, S_PLL_RST, S_FAULT};
      clk_en_q    <= (state_d == S_RUN);
      pix_rst_n_q <= (state_d == S_RUN) && (cnt_d >= REL);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  assign bus.pll_reset    = pll_reset_q;
  assign bus.clk_en       = clk_en_q;
  assign bus.pix_rst_n    = pix_rst_n_q;
  assign bus.fault        = fault_q;
  assign bus.state        = state_q;
  assign bus.relock_count = relock_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scenario bench for pll_lock_sequencer; expected timing is derived
// arithmetically from the sequencing rules with small parameters.
module tb_pll_lock_sequencer;
  localparam int RC = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int RR = 3;
  localparam int MR = 2;
  localparam int UP = 1 + RC + 1 + SC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   exp_relock = 0;

  pll_lock_sequencer_if bus();

  pll_lock_sequencer #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .SETTLE_CYCLES(SC),
    .RST_RELEASE  (RR),
    .MAX_RETRIES  (MR),
    .CNT_W        (20)
  ) dut (
    .in_clk  (clk),
    .in_rst_n(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs, expv;
    bus.enable   = 1'b0;
    bus.pll_lock = 1'b0;
    rst_n        = 1'b0;
    step(2);
    obs  = {bus.pll_reset, bus.clk_en, bus.pix_rst_n,
            bus.fault, 1'b0, bus.state};
    expv = 8'b1000_0000;
    checks++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL reset_outputs got=%b exp=%b", obs, expv);
    end
    checks++;
    if (bus.relock_count !== 8'd0) begin
      errs++;
      $display("FAIL reset_relock got=%0d exp=0", bus.relock_count);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  // Assumes enable is already 1 and the DUT sits in IDLE before edge 1.
  task automatic run_bringup(input string tag);
    logic [2:0] obs, expv;
    for (int t = 1; t <= UP + RR + 2; t++) begin
      step(1);
      expv = {t < 1 + RC, t >= UP, t >= UP + RR};
      obs  = {bus.pll_reset, bus.clk_en, bus.pix_rst_n};
      checks++;
      if (obs !== expv) begin
        errs++;
        $display("FAIL %s t=%0d rst/ce/prn got=%b exp=%b",
                 tag, t, obs, expv);
      end
    end
    checks++;
    if (bus.state !== 3'd4) begin
      errs++;
      $display("FAIL %s_state got=%0d exp=4", tag, bus.state);
    end
  endtask

  task automatic test_bringup();
    bus.pll_lock = 1'b1;
    bus.enable   = 1'b0;
    step(3);
    bus.enable = 1'b1;
    run_bringup("bringup");
  endtask

  task automatic test_enable_drop();
    logic [6:0] obs, expv;
    bus.enable = 1'b0;
    step(1);
    obs  = {bus.pll_reset, bus.clk_en, bus.pix_rst_n,
            bus.fault, bus.state};
    expv = 7'b1000_000;
    checks++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL enable_drop got=%b exp=%b", obs, expv);
    end
  endtask

  task automatic test_settle_abort();
    int a;
    int want;
    bus.pll_lock = 1'b1;
    bus.enable   = 1'b0;
    step(3);
    a = int'($urandom_range(11, 6));
    bus.enable = 1'b1;
    for (int t = 1; t <= a + 15; t++) begin
      bus.pll_lock = !(t == a || t == a + 1);
      step(1);
      checks++;
      if (bus.clk_en !== (t >= a + 12)) begin
        errs++;
        $display("FAIL settle_clk_en t=%0d got=%b exp=%b",
                 t, bus.clk_en, t >= a + 12);
      end
      want = -1;
      if (t == a + 2 || t == a + 3) want = 2;
      if (t == a + 4) want = 3;
      if (t == a + 12) want = 4;
      if (want >= 0) begin
        checks++;
        if (int'(bus.state) != want) begin
          errs++;
          $display("FAIL settle_state t=%0d got=%0d exp=%0d",
                   t, bus.state, want);
        end
      end
    end
  endtask

  task automatic test_timeout_fault();
    int per;
    int fe;
    logic [1:0] obs, expv;
    per = RC + LT;
    fe  = 1 + MR * per;
    bus.enable   = 1'b0;
    bus.pll_lock = 1'b0;
    step(3);
    for (int r = 0; r < 2; r++) begin
      bus.enable = 1'b1;
      for (int t = 1; t <= fe + 2; t++) begin
        step(1);
        expv = 2'b11;
        if (t < fe) expv = {((t - 1) % per) < RC, 1'b0};
        obs = {bus.pll_reset, bus.fault};
        checks++;
        if (obs !== expv) begin
          errs++;
          $display("FAIL timeout r=%0d t=%0d rst/fault got=%b exp=%b",
                   r, t, obs, expv);
        end
      end
      checks++;
      if (bus.state !== 3'd5) begin
        errs++;
        $display("FAIL fault_state got=%0d exp=5", bus.state);
      end
      bus.enable = 1'b0;
      step(1);
      checks++;
      if ({bus.state, bus.fault, bus.pll_reset} !== 5'b000_0_1) begin
        errs++;
        $display("FAIL fault_exit state=%0d fault=%b exp state=0 fault=0",
                 bus.state, bus.fault);
      end
    end
  endtask

  // Drop lock for d cycles while in RUN; returns rise edge of clk_en.
  task automatic lock_loss(input int d, input string tag);
    int rise;
    logic [1:0] obs, expv;
    rise = ((d + 3 > 4 + RC) ? d + 3 : 4 + RC) + SC;
    if (exp_relock < 255) exp_relock++;
    for (int t = 1; t <= rise + RR + 1; t++) begin
      bus.pll_lock = (t > d);
      step(1);
      expv = {t < 3 || t >= rise, t < 3 || t >= rise + RR};
      obs  = {bus.clk_en, bus.pix_rst_n};
      checks++;
      if (obs !== expv) begin
        errs++;
        $display("FAIL %s d=%0d t=%0d ce/prn got=%b exp=%b",
                 tag, d, t, obs, expv);
      end
      if (t == 3) begin
        checks++;
        if (bus.state !== 3'd1) begin
          errs++;
          $display("FAIL %s_state_loss got=%0d exp=1", tag, bus.state);
        end
      end
    end
    checks++;
    if (int'(bus.relock_count) != exp_relock ||
        bus.state !== 3'd4) begin
      errs++;
      $display("FAIL %s_relock got=%0d/%0d exp=%0d/4", tag,
               bus.relock_count, bus.state, exp_relock);
    end
  endtask

  task automatic test_lock_loss();
    bus.pll_lock = 1'b1;
    bus.enable   = 1'b0;
    step(3);
    bus.enable = 1'b1;
    step(UP + RR + 2);
    for (int i = 0; i < 8; i++) begin
      step(int'($urandom_range(5, 0)));
      lock_loss(int'($urandom_range(24, 1)), "lock_loss");
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 258; i++) lock_loss(1, "saturate");
    checks++;
    if (bus.relock_count !== 8'd255) begin
      errs++;
      $display("FAIL saturate_final got=%0d exp=255", bus.relock_count);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] obs, expv;
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    exp_relock = 0;
    obs  = {bus.pll_reset, bus.clk_en, bus.pix_rst_n,
            bus.fault, bus.state};
    expv = 7'b1000_000;
    checks++;
    if (obs !== expv) begin
      errs++;
      $display("FAIL async_reset got=%b exp=%b", obs, expv);
    end
    checks++;
    if (bus.relock_count !== 8'd0) begin
      errs++;
      $display("FAIL async_relock got=%0d exp=0", bus.relock_count);
    end
    #3;
    rst_n = 1'b1;
    run_bringup("after_reset");
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_enable_drop();
    test_settle_abort();
    test_timeout_fault();
    test_lock_loss();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
